// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub.
// The slave modport is the arithmetic unit and the master modport is the producer/consumer side.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carry, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement add/sub/neg/abs unit with one shared DIGIT-bit adder slice.
// Defining SERIAL_ADDSUB_SAT_EN saturates the result on signed overflow.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);
  localparam int unsigned K  = WIDTH / DIGIT;
  localparam int unsigned CW = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [1:0]       op_q, op_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             ovalid_q, ovalid_d;

  logic [DIGIT-1:0] sum;
  logic             c, c_msb;
  logic [WIDTH-1:0] acc_shift;
  logic [WIDTH-1:0] final_res;

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = ovalid_q;
  assign bus.result    = res_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      cy_q     <= cy_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      ovalid_q <= ovalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    op_d     = op_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    ovalid_d = ovalid_q;

    // Shared slice; c_msb keeps the carry into the slice's top bit for overflow.
    sum   = '0;
    c     = cy_q;
    c_msb = cy_q;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      c_msb  = c;
      sum[i] = x_q[i] ^ y_q[i] ^ c;
      c      = (x_q[i] & y_q[i]) | (c & (x_q[i] ^ y_q[i]));
    end
    acc_shift = (acc_q >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));

    final_res = acc_shift;
`ifdef SERIAL_ADDSUB_SAT_EN
    if (c ^ c_msb) begin
      final_res = acc_shift[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                     : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.a;
          y_d     = bus.b;
          op_d    = bus.op;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        // Count 0 turns the captured a/b into (x, y, cin); counts 1..K add digits.
        if (cnt_q == '0) begin
          unique case (op_q)
            2'b00: cy_d = 1'b0;
            2'b01: begin y_d = ~y_q; cy_d = 1'b1; end
            2'b10: begin x_d = '0; y_d = ~x_q; cy_d = 1'b1; end
            default: begin
              if (x_q[WIDTH-1]) begin
                x_d = '0; y_d = ~x_q; cy_d = 1'b1;
              end else begin
                y_d = '0; cy_d = 1'b0;
              end
            end
          endcase
        end else begin
          x_d   = x_q >> DIGIT;
          y_d   = y_q >> DIGIT;
          cy_d  = c;
          acc_d = acc_shift;
          if (cnt_q == CW'(K)) begin
            state_d  = DONE;
            ovalid_d = 1'b1;
            carry_d  = c;
            ovf_d    = c ^ c_msb;
            res_d    = final_res;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d  = IDLE;
          ovalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: WIDTH=8/DIGIT=1 with a scoreboard, plus WIDTH=4 NEG sweeps at DIGIT=2 and DIGIT=4.
module tb_serial_addsub;
`ifdef SERIAL_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       o;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) bus8 ();
  serial_addsub_if #(.WIDTH(4)) bus4a ();
  serial_addsub_if #(.WIDTH(4)) bus4b ();

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_addsub #(.WIDTH(4), .DIGIT(2)) dut4a (.clk(clk), .rst(rst), .bus(bus4a));
  serial_addsub #(.WIDTH(4), .DIGIT(4)) dut4b (.clk(clk), .rst(rst), .bus(bus4b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Value-level model: true signed result, range check, then wrap or clamp.
  function automatic exp_t model(input int w, input logic [1:0] op,
                                 input logic [7:0] a, input logic [7:0] b);
    exp_t m;
    int mask, ua, ub, sa, sb, t, mx, mn, r;
    mask = (1 << w) - 1;
    ua = int'(a) & mask;
    ub = int'(b) & mask;
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    case (op)
      2'b00:   begin t = sa + sb; m.c = (((ua + ub) >> w) & 1) != 0; end
      2'b01:   begin t = sa - sb; m.c = (ua >= ub); end
      2'b10:   begin t = -sa;     m.c = (ua == 0); end
      default: begin t = (sa < 0) ? -sa : sa; m.c = 1'b0; end
    endcase
    m.o = (t > mx) || (t < mn);
    r = t;
    if (SAT && m.o) r = (t > 0) ? mx : mn;
    m.res = 8'(r & mask);
    return m;
  endfunction

  // Scoreboard for the 8-bit unit: push on accept, compare every DONE cycle.
  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
    end else begin
      if (bus8.in_valid && bus8.in_ready)
        q8.push_back(model(8, bus8.op, bus8.a, bus8.b));
      if (bus8.out_valid) begin
        if (q8.size() == 0) begin
          chk("sb_unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          chk("sb_result",   32'(bus8.result),   32'(q8[0].res));
          chk("sb_carry",    32'(bus8.carry),    32'(q8[0].c));
          chk("sb_overflow", 32'(bus8.overflow), 32'(q8[0].o));
          if (bus8.out_ready) void'(q8.pop_front());
        end
      end
    end
  end

  // Entered at posedge+1 with the 8-bit unit idle.
  task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b,
                     input logic [1:0] op, input logic [7:0] er, input logic ec,
                     input logic eo, input bit consume);
    exp_t m;
    int   n;
    m = model(8, op, a, b);
    chk({nm, "_model_res"}, 32'(m.res), 32'(er));
    chk({nm, "_model_c"},   32'(m.c),   32'(ec));
    chk({nm, "_model_o"},   32'(m.o),   32'(eo));
    bus8.a = a; bus8.b = b; bus8.op = op; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0; bus8.a = ~a; bus8.b = ~b; bus8.op = ~op;
    n = 0;
    while (!bus8.out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_latency"},  32'(n), 32'd9);
    chk({nm, "_result"},   32'(bus8.result),   32'(er));
    chk({nm, "_carry"},    32'(bus8.carry),    32'(ec));
    chk({nm, "_overflow"}, 32'(bus8.overflow), 32'(eo));
    if (consume) begin
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int   seen, n, la, lb;
    exp_t m;
    logic [3:0] e4;
    bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.op = '0;  bus8.out_ready = 1'b0;
    bus4a.in_valid = 1'b0; bus4a.a = '0; bus4a.b = '0; bus4a.op = '0; bus4a.out_ready = 1'b0;
    bus4b.in_valid = 1'b0; bus4b.a = '0; bus4b.b = '0; bus4b.op = '0; bus4b.out_ready = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus8.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_result",    32'(bus8.result),    32'd0);
    chk("rst_carry",     32'(bus8.carry),     32'd0);
    chk("rst_overflow",  32'(bus8.overflow),  32'd0);
    rst = 1'b0;
    #1 chk("idle_in_ready", 32'(bus8.in_ready), 32'd1);

    op8("add_7f_01", 8'h7F, 8'h01, 2'b00, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b1);
    op8("sub_05_07", 8'h05, 8'h07, 2'b01, 8'hFE, 1'b0, 1'b0, 1'b1);
    op8("sub_07_05", 8'h07, 8'h05, 2'b01, 8'h02, 1'b1, 1'b0, 1'b1);
    op8("neg_80",    8'h80, 8'h3C, 2'b10, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b1);
    op8("abs_fb",    8'hFB, 8'h00, 2'b11, 8'h05, 1'b0, 1'b0, 1'b1);
    op8("abs_05",    8'h05, 8'hFF, 2'b11, 8'h05, 1'b0, 1'b0, 1'b1);
    op8("add_ff_01", 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1);
    op8("neg_00",    8'h00, 8'h00, 2'b10, 8'h00, 1'b1, 1'b0, 1'b1);

    // Backpressure: hold DONE five cycles with in_valid pulses that must be ignored.
    op8("bp", 8'h80, 8'h01, 2'b01, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = (i % 2 == 0); bus8.a = 8'h11; bus8.b = 8'h22; bus8.op = 2'b00;
      @(posedge clk); #1;
      chk("bp_in_ready",  32'(bus8.in_ready),  32'd0);
      chk("bp_out_valid", 32'(bus8.out_valid), 32'd1);
      chk("bp_result",    32'(bus8.result),    SAT ? 32'h80 : 32'h7F);
    end
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    chk("bp_release_in_ready",  32'(bus8.in_ready),  32'd1);
    chk("bp_release_out_valid", 32'(bus8.out_valid), 32'd0);
    op8("after_bp", 8'h22, 8'h33, 2'b00, 8'h55, 1'b0, 1'b0, 1'b1);

    // Reset while digit 3 is in flight.
    bus8.a = 8'h33; bus8.b = 8'h44; bus8.op = 2'b00; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_in_ready",  32'(bus8.in_ready),  32'd0);
    chk("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("midrst_result",    32'(bus8.result),    32'd0);
    chk("midrst_carry",     32'(bus8.carry),     32'd0);
    chk("midrst_overflow",  32'(bus8.overflow),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus8.out_valid) seen = 1;
    end
    chk("midrst_no_stale", 32'(seen), 32'd0);
    op8("post_rst_add", 8'h10, 8'h20, 2'b00, 8'h30, 1'b0, 1'b0, 1'b1);

    // WIDTH=4 NEG sweep on both DIGIT=2 and DIGIT=4 units side by side.
    for (int i = 0; i < 16; i++) begin
      e4 = 4'((16 - i) % 16);
      if (SAT && i == 8) e4 = 4'h7;
      m = model(4, 2'b10, 8'(i), 8'h00);
      chk("neg4_model", 32'(m.res), 32'(e4));
      bus4a.a = 4'(i); bus4a.b = 4'h5; bus4a.op = 2'b10; bus4a.in_valid = 1'b1;
      bus4b.a = 4'(i); bus4b.b = 4'hA; bus4b.op = 2'b10; bus4b.in_valid = 1'b1;
      @(posedge clk); #1;
      bus4a.in_valid = 1'b0; bus4b.in_valid = 1'b0;
      bus4a.a = 4'hF; bus4b.a = 4'hF;
      la = 0; lb = 0; n = 0;
      while ((la == 0 || lb == 0) && n < 20) begin
        @(posedge clk); #1; n++;
        if (bus4a.out_valid && la == 0) la = n;
        if (bus4b.out_valid && lb == 0) lb = n;
      end
      chk("neg4_d2_latency", 32'(la), 32'd3);
      chk("neg4_d4_latency", 32'(lb), 32'd2);
      chk("neg4_d2_result",  32'(bus4a.result), 32'(e4));
      chk("neg4_d4_result",  32'(bus4b.result), 32'(e4));
      chk("neg4_d2_overflow", 32'(bus4a.overflow), 32'(i == 8));
      chk("neg4_d4_overflow", 32'(bus4b.overflow), 32'(m.o));
      chk("neg4_d2_carry",   32'(bus4a.carry), 32'(i == 0));
      bus4a.out_ready = 1'b1; bus4b.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4a.out_ready = 1'b0; bus4b.out_ready = 1'b0;
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
